sram_arbiter: RTL

//  Shares one asynchronous 32-bit SRAM chip between the instruction-fetch port (IF) and the

---
 rtl/sram_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between the instruction-fetch and data-memory ports.
// The data port has priority, but a streak counter lets fetch through after MAX_STREAK data grants.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [19:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [19:0] mem_addr,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    inout  wire  [31:0] ram_data,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    logic          owner_if;
    logic          lat_we;
    logic          drive_en;
    logic [31:0]   lat_wdata;
    logic          grant_if;
    logic          mem_write;
    logic          skip_access;

    // The bus is only ever driven for writes, which keep oe_n high.
    assign ram_data = drive_en ? lat_wdata : {32{1'bz}};

    always_comb begin
        grant_if    = if_req && (!mem_req || streak == STREAK_MAX);
        mem_write   = !grant_if && mem_we;
        skip_access = mem_write && (mem_be == 4'b0000);
        streak_nxt  = streak;
        if (grant_if || !if_req)
            streak_nxt = '0;
        else if (streak != STREAK_MAX)
            streak_nxt = streak + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            streak    <= '0;
            owner_if  <= 1'b0;
            lat_we    <= 1'b0;
            drive_en  <= 1'b0;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_be_n  <= 4'hF;
            ram_addr  <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || mem_req) begin
                        streak    <= streak_nxt;
                        owner_if  <= grant_if;
                        lat_we    <= mem_write;
                        lat_wdata <= mem_wdata;
                        wait_cnt  <= CW'(WAIT_CYCLES - 1);
                        if (skip_access) begin
                            // Nothing to write: acknowledge without touching the chip.
                            state   <= S_DONE;
                            mem_ack <= 1'b1;
                        end else begin
                            state    <= S_ACCESS;
                            ram_ce_n <= 1'b0;
                            ram_addr <= grant_if ? if_addr : mem_addr;
                            if (mem_write) begin
                                ram_we_n <= 1'b0;
                                ram_be_n <= ~mem_be;
                                drive_en <= 1'b1;
                            end else begin
                                ram_oe_n <= 1'b0;
                                ram_be_n <= 4'b0000;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state    <= S_DONE;
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        ram_be_n <= 4'hF;
                        if (!lat_we) begin
                            if (owner_if)
                                if_rdata <= ram_data;
                            else
                                mem_rdata <= ram_data;
                        end
                        if (owner_if)
                            if_ack <= 1'b1;
                        else
                            mem_ack <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    // Address and write data are held through this cycle for SRAM hold time.
                    state    <= S_IDLE;
                    drive_en <= 1'b0;
                    ram_addr <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
